coeff_streamer: RTL and testbench
=================================

COEFF_STREAMER -- requirements
Module: coeff_streamer

Interface
REQ-001 The block SHALL have parameter NUM_COEFF, default 9, number of coefficients per filter.
REQ-002 The block SHALL have parameter COEFF_W, default 8, width of one coefficient in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to transmit filter_in; sampled on the rising edge.
REQ-006 The block SHALL have port filter_in, input, NUM_COEFF*COEFF_W (72), packed filter; coefficient k occupies bits [8k+7:8k].
REQ-007 The block SHALL have port hold, input, 1, downstream stall; 1 pauses transmission.
REQ-008 The block SHALL have port coeff_load, output, 1, 1 when coeff_in carries a valid coefficient this cycle.
REQ-009 The block SHALL have port coeff_in, output, COEFF_W, current coefficient byte.
REQ-010 The block SHALL have port busy, output, 1, high from the cycle after an accepted start until the last byte is sent.
REQ-011 The block SHALL have port data_load, output, 1, high once a complete filter is sent; low again on the next accepted start.
REQ-012 The block SHALL have port done, output, 1, single-cycle pulse in the cycle after the last byte.

Function
REQ-013 The FSM SHALL have states IDLE, SEND and DONE.
REQ-014 In IDLE, start=1 SHALL snapshot filter_in into an internal register, clear the coefficient index to 0, clear data_load and enter SEND.
REQ-015 In SEND, each cycle with hold=0 SHALL drive coeff_load=1 and coeff_in=snapshot[8*idx+7:8*idx], then increment idx.
REQ-016 In SEND with hold=1, coeff_load SHALL be 0, coeff_in SHALL hold its last value, and idx SHALL not change.
REQ-017 Coefficients SHALL be sent in order idx=0..NUM_COEFF-1, exactly once each.
REQ-018 coeff_load and coeff_in SHALL be registered outputs: the byte for idx appears in the cycle after the edge that selected it.
REQ-019 Zero-stall latency SHALL be: start sampled at edge N; byte 0 valid in cycle N+1; byte 8 valid in cycle N+9; done=1 in cycle N+10.
REQ-020 When idx=NUM_COEFF-1 is sent, the FSM SHALL enter DONE; DONE SHALL last one cycle, assert done, set data_load=1 and return to IDLE.
REQ-021 start while in SEND or DONE SHALL be ignored; filter_in changes after the snapshot SHALL not affect the bytes sent.
REQ-022 start asserted in the IDLE cycle immediately after DONE SHALL be accepted, giving back-to-back transfers with one idle cycle between.
REQ-023 idx SHALL be ceil(log2(NUM_COEFF+1)) bits wide, never exceed NUM_COEFF-1 while in SEND, and never wrap.
REQ-024 hold asserted in IDLE or DONE SHALL have no effect.

Reset
REQ-025 With rst=0, at any time including mid-SEND, the block SHALL enter IDLE with coeff_load=0, coeff_in=0, busy=0, data_load=0, done=0, idx=0 and snapshot=0.
REQ-026 A transfer aborted by reset SHALL not resume; the first start after rst deasserts begins again at idx=0.

Structure
REQ-027 The shared package conv_pkg SHALL hold NUM_COEFF, COEFF_W, FILTER_W=NUM_COEFF*COEFF_W, and the state enum type (IDLE, SEND, DONE).
REQ-028 The block SHALL be a single module with no sub-modules; the snapshot register and byte mux SHALL be inline.

Verification
REQ-029 The bench SHALL apply reset, then filter_in=72'h83_FF_7F_3F_1F_0F_07_03_01 and a one-cycle start with hold=0; coeff_in SHALL be 01,03,07,0F,1F,3F,7F,FF,83 on 9 consecutive cycles with coeff_load=1, then done pulses once and data_load=1.
REQ-030 The bench SHALL repeat REQ-029 with hold=1 for 2 cycles after byte 3 (0F); coeff_load SHALL be 0 for 2 cycles with coeff_in=0F, the sequence SHALL resume with 1F, and done SHALL occur at N+12.
REQ-031 The bench SHALL change filter_in to all-zero and pulse start again during SEND; the full original sequence SHALL complete unchanged with exactly one done.
REQ-032 The bench SHALL assert rst=0 asynchronously (between edges) after byte 4; all outputs SHALL read 0 immediately; a new start with filter_in=72'hAA..AA SHALL yield 9 bytes of AA.
REQ-033 The bench SHALL hold start=1 continuously; transfers SHALL repeat with a 1-cycle IDLE gap, data_load SHALL drop on each accepted start, and exactly 9 coeff_load pulses SHALL occur per done.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and the state type for the coefficient streamer.
// Default geometry is nine 8-bit coefficients packed into a 72-bit filter word.
package conv_pkg;

  localparam int NUM_COEFF = 9;
  localparam int COEFF_W   = 8;
  localparam int FILTER_W  = NUM_COEFF * COEFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/coeff_streamer.sv
// Snapshots a packed filter on start and streams its coefficients one per cycle,
// lowest index first, pausing while hold is high.
module coeff_streamer
  import conv_pkg::*;
#(
  parameter int NUM_COEFF = conv_pkg::NUM_COEFF,
  parameter int COEFF_W   = conv_pkg::COEFF_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_COEFF*COEFF_W-1:0] filter_in,
  input  logic                         hold,
  output logic                         coeff_load,
  output logic [COEFF_W-1:0]           coeff_in,
  output logic                         busy,
  output logic                         data_load,
  output logic                         done
);

  localparam int FW    = NUM_COEFF * COEFF_W;
  localparam int IDX_W = $clog2(NUM_COEFF + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FW-1:0]      snap_q, snap_d;
  logic               coeff_load_q, coeff_load_d;
  logic [COEFF_W-1:0] coeff_in_q, coeff_in_d;
  logic               busy_q, busy_d;
  logic               data_load_q, data_load_d;
  logic               done_q, done_d;

  always_comb begin
    // NOTE: every _d starts from a default so no path through the case leaves it unassigned (no latches).
    state_d      = state_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    coeff_load_d = 1'b0;
    coeff_in_d   = coeff_in_q;
    busy_d       = busy_q;
    data_load_d  = data_load_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d      = filter_in;
          idx_d       = '0;
          data_load_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (!hold) begin
          coeff_load_d = 1'b1;
          coeff_in_d   = snap_q[int'(idx_q) * COEFF_W +: COEFF_W];
          // idx parks on the last coefficient rather than stepping past it.
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        done_d      = 1'b1;
        data_load_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the snapshot is a plain register, not a RAM, so clearing it on reset is cheap and keeps state deterministic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_q       <= '0;
      coeff_load_q <= 1'b0;
      coeff_in_q   <= '0;
      busy_q       <= 1'b0;
      data_load_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values computed above.
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      coeff_load_q <= coeff_load_d;
      coeff_in_q   <= coeff_in_d;
      busy_q       <= busy_d;
      data_load_q  <= data_load_d;
      done_q       <= done_d;
    end
  end

  assign coeff_load = coeff_load_q;
  assign coeff_in   = coeff_in_q;
  assign busy       = busy_q;
  assign data_load  = data_load_q;
  assign done       = done_q;

endmodule

// File: tb/tb_coeff_streamer.sv
// Self-checking bench for coeff_streamer: directed transfer scenarios plus
// randomized start/hold/filter traffic compared against a queue-based model.
module tb_coeff_streamer;
  import conv_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start_i = 1'b0;
  logic                hold_i = 1'b0;
  logic [FILTER_W-1:0] filter_i = '0;
  logic                coeff_load;
  logic [COEFF_W-1:0]  coeff_in;
  logic                busy;
  logic                data_load;
  logic                done;

  coeff_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start_i),
    .filter_in  (filter_i),
    .hold       (hold_i),
    .coeff_load (coeff_load),
    .coeff_in   (coeff_in),
    .busy       (busy),
    .data_load  (data_load),
    .done       (done)
  );

  always #5 clk = ~clk;

  localparam logic [FILTER_W-1:0] FILT_A  = 72'h83_FF_7F_3F_1F_0F_07_03_01;
  localparam logic [FILTER_W-1:0] FILT_AA = {NUM_COEFF{8'hAA}};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transfer is a queue of the snapshot's bytes; each
  // unstalled cycle pops one, and one cycle after the queue empties done fires.
  typedef enum int {M_IDLE, M_SENDING, M_FINISH} mode_e;
  mode_e              m_mode;
  logic [COEFF_W-1:0] m_q[$];
  logic               exp_load, exp_busy, exp_dl, exp_done;
  logic [COEFF_W-1:0] exp_byte;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_q.delete();
    exp_load = 1'b0; exp_busy = 1'b0; exp_dl = 1'b0; exp_done = 1'b0;
    exp_byte = '0;
  endtask

  task automatic model_step();
    exp_load = 1'b0;
    exp_done = 1'b0;
    case (m_mode)
      M_IDLE: if (start_i) begin
        m_q.delete();
        for (int k = 0; k < NUM_COEFF; k++) m_q.push_back(filter_i[k*COEFF_W +: COEFF_W]);
        exp_dl   = 1'b0;
        exp_busy = 1'b1;
        m_mode   = M_SENDING;
      end
      M_SENDING: if (!hold_i) begin
        exp_byte = m_q.pop_front();
        exp_load = 1'b1;
        if (m_q.size() == 0) m_mode = M_FINISH;
      end
      default: begin
        exp_done = 1'b1;
        exp_dl   = 1'b1;
        exp_busy = 1'b0;
        m_mode   = M_IDLE;
      end
    endcase
  endtask

  logic [COEFF_W-1:0] got_q[$];
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int loads_since_done = 0;

  task automatic clear_obs();
    got_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // One clock: drive inputs, let the edge happen, then compare 1 time unit later.
  task automatic step(input logic s, input logic h);
    start_i = s;
    hold_i  = h;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check("coeff_load", 32'(coeff_load), 32'(exp_load));
    check("coeff_in",   32'(coeff_in),   32'(exp_byte));
    check("busy",       32'(busy),       32'(exp_busy));
    check("data_load",  32'(data_load),  32'(exp_dl));
    check("done",       32'(done),       32'(exp_done));
    if (coeff_load) begin
      got_q.push_back(coeff_in);
      loads_since_done++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("loads_per_done", 32'(loads_since_done), 32'(NUM_COEFF));
      loads_since_done = 0;
    end
  endtask

  task automatic check_seq(input string tag, input logic [FILTER_W-1:0] f);
    logic [FILTER_W-1:0] fv;
    fv = f;
    check({tag, "_len"}, 32'(got_q.size()), 32'(NUM_COEFF));
    for (int k = 0; k < NUM_COEFF && k < got_q.size(); k++)
      check({tag, "_byte"}, 32'(got_q[k]), 32'(fv[k*COEFF_W +: COEFF_W]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_coeff_load"}, 32'(coeff_load), 32'd0);
    check({tag, "_coeff_in"},   32'(coeff_in),   32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_data_load"},  32'(data_load),  32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
  endtask

  // Called #1 after an edge: drops reset between edges, checks, releases on negedge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    loads_since_done = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int n;
  logic [7:0] exp_seq [NUM_COEFF];

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Plain transfer, no stalls; sequence checked against literal byte values.
    exp_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h83};
    filter_i = FILT_A;
    clear_obs();
    step(1'b1, 1'b0);
    n = cyc;
    repeat (11) step(1'b0, 1'b0);
    check("plain_len", 32'(got_q.size()), 32'(NUM_COEFF));
    for (int k = 0; k < NUM_COEFF && k < got_q.size(); k++)
      check("plain_literal_byte", 32'(got_q[k]), 32'(exp_seq[k]));
    check("plain_done_count", 32'(done_cnt), 32'd1);
    check("plain_done_cycle", 32'(done_cyc), 32'(n + 10));
    check("plain_data_load", 32'(data_load), 32'd1);

    // Two-cycle stall right after byte 3.
    clear_obs();
    step(1'b1, 1'b0);
    n = cyc;
    repeat (4) step(1'b0, 1'b0);
    repeat (2) begin
      step(1'b0, 1'b1);
      check("hold_coeff_in",   32'(coeff_in),   32'h0F);
      check("hold_coeff_load", 32'(coeff_load), 32'd0);
    end
    step(1'b0, 1'b0);
    check("hold_resume", 32'(coeff_in), 32'h1F);
    repeat (7) step(1'b0, 1'b0);
    check_seq("hold_seq", FILT_A);
    check("hold_done_cycle", 32'(done_cyc), 32'(n + 12));

    // Filter changes and a second start mid-transfer are ignored.
    clear_obs();
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    filter_i = '0;
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    check_seq("ignore_seq", FILT_A);
    check("ignore_done_count", 32'(done_cnt), 32'd1);

    // Asynchronous reset after byte 4, then a fresh AA transfer.
    filter_i = FILT_A;
    clear_obs();
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    check("pre_abort_byte4", 32'(coeff_in), 32'h1F);
    async_reset("abort");
    filter_i = FILT_AA;
    clear_obs();
    step(1'b1, 1'b0);
    n = cyc;
    repeat (11) step(1'b0, 1'b0);
    check_seq("after_abort_seq", FILT_AA);
    check("after_abort_done_cycle", 32'(done_cyc), 32'(n + 10));

    // start held high: back-to-back transfers with one idle cycle between.
    filter_i = FILT_A;
    clear_obs();
    repeat (40) step(1'b1, 1'b0);
    check("b2b_done_count", 32'(done_cnt), 32'd3);
    repeat (12) step(1'b0, 1'b0);

    // Randomized traffic with occasional asynchronous resets.
    repeat (400) begin
      for (int k = 0; k < NUM_COEFF; k++) filter_i[k*COEFF_W +: COEFF_W] = 8'($urandom());
      if ($urandom_range(0, 149) == 0) async_reset("rand_reset");
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
